// File: rtl/lif_pkg.sv
// Shared FSM type, defaults and saturating add for the LIF neuron array.
// Optional feature macro: ADAPTIVE_THRESH_EN (per-neuron threshold offsets).
package lif_pkg;

  typedef enum logic {
    RUN,
    CLEAR
  } lif_state_e;

  localparam int unsigned LIF_WIDTH       = 8;
  localparam int unsigned LIF_NUM_NEURONS = 4;
  localparam int unsigned LIF_LEAK_SHIFT  = 2;
  localparam int unsigned LIF_REFRACTORY  = 2;

  // Unsigned add clamped to the all-ones value of a w-bit word.
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [31:0] mx;
    if (w >= 32) mx = '1;
    else mx = (32'd1 << w) - 32'd1;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, mx}) ? mx : s[31:0];
  endfunction

endpackage

// File: rtl/lif_core.sv
// Combinational leaky integrate-and-fire update for one neuron.
// Optional macro ADAPTIVE_THRESH_EN only changes what drives offset.
module lif_core
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH      = LIF_WIDTH,
  parameter int unsigned LEAK_SHIFT = LIF_LEAK_SHIFT,
  parameter int unsigned REFRACTORY = LIF_REFRACTORY,
  parameter int unsigned REF_W      = 2
) (
  input  logic [WIDTH-1:0] state,
  input  logic [REF_W-1:0] ref_cnt,
  input  logic [WIDTH-1:0] current,
  input  logic [WIDTH-1:0] threshold,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] next_state,
  output logic [REF_W-1:0] next_ref,
  output logic [WIDTH-1:0] v,
  output logic             spike
);

  logic [WIDTH-1:0] leaked;
  logic [31:0]      sum;
  logic [31:0]      eff_th;

  assign leaked = state - (state >> LEAK_SHIFT);
  assign sum    = sat_add(32'(leaked), 32'(current), WIDTH);
  assign eff_th = sat_add(32'(threshold), 32'(offset), WIDTH);

  always_comb begin
    next_state = state;
    next_ref   = ref_cnt;
    v          = '0;
    spike      = 1'b0;
    if (ref_cnt != '0) begin
      next_ref   = ref_cnt - REF_W'(1);
      next_state = '0;
    end else begin
      v          = sum[WIDTH-1:0];
      spike      = (sum >= eff_th);
      next_state = spike ? '0 : v;
      next_ref   = spike ? REF_W'(REFRACTORY) : '0;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array: round-robin updates, sweep spike vector.
// Optional macro ADAPTIVE_THRESH_EN adds per-neuron adaptive threshold offsets.
module lif_array
  import lif_pkg::*;
#(
  parameter int unsigned WIDTH       = LIF_WIDTH,
  parameter int unsigned NUM_NEURONS = LIF_NUM_NEURONS,
  parameter int unsigned LEAK_SHIFT  = LIF_LEAK_SHIFT,
  parameter int unsigned REFRACTORY  = LIF_REFRACTORY
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [WIDTH-1:0]               threshold,
  input  logic                           clear,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               current,
  output logic [WIDTH-1:0]               state_out,
  output logic [$clog2(NUM_NEURONS)-1:0] state_idx,
  output logic                           spike_out,
  output logic [NUM_NEURONS-1:0]         spikes,
  output logic                           spikes_valid
);

  localparam int unsigned PW    = $clog2(NUM_NEURONS);
  localparam int unsigned REF_W =
    (REFRACTORY == 0) ? 1 : $clog2(REFRACTORY + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_NEURONS - 1);

  lif_state_e fsm_q, fsm_d;

  logic [PW-1:0]          ptr_q;
  logic [WIDTH-1:0]       state_q [NUM_NEURONS];
  logic [REF_W-1:0]       ref_q   [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] acc_q;
  logic [NUM_NEURONS-1:0] acc_hit;

  logic [WIDTH-1:0] cur_off;
  logic [WIDTH-1:0] nxt_state;
  logic [REF_W-1:0] nxt_ref;
  logic [WIDTH-1:0] v;
  logic             spike;
  logic             beat;
  logic             last;

  assign beat      = in_valid && in_ready;
  assign last      = (ptr_q == LAST);
  assign state_idx = ptr_q;
  assign acc_hit   = acc_q | (NUM_NEURONS'(spike) << ptr_q);

  lif_core #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACTORY (REFRACTORY),
    .REF_W      (REF_W)
  ) u_core (
    .state      (state_q[ptr_q]),
    .ref_cnt    (ref_q[ptr_q]),
    .current    (current),
    .threshold  (threshold),
    .offset     (cur_off),
    .next_state (nxt_state),
    .next_ref   (nxt_ref),
    .v          (v),
    .spike      (spike)
  );

  always_comb begin
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    unique case (fsm_q)
      RUN: begin
        in_ready = !clear;
        if (clear) fsm_d = CLEAR;
      end
      CLEAR: begin
        if (last) fsm_d = RUN;
      end
      default: fsm_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= RUN;
      ptr_q        <= '0;
      acc_q        <= '0;
      state_out    <= '0;
      spike_out    <= 1'b0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i] <= '0;
        ref_q[i]   <= '0;
      end
    end else begin
      fsm_q        <= fsm_d;
      spike_out    <= 1'b0;
      spikes_valid <= 1'b0;
      if (fsm_q == CLEAR) begin
        state_q[ptr_q] <= '0;
        ref_q[ptr_q]   <= '0;
        ptr_q          <= last ? '0 : ptr_q + PW'(1);
      end else if (clear) begin
        // abandon the partial sweep; the walk starts at neuron 0
        ptr_q <= '0;
        acc_q <= '0;
      end else if (beat) begin
        state_q[ptr_q] <= nxt_state;
        ref_q[ptr_q]   <= nxt_ref;
        state_out      <= v;
        spike_out      <= spike;
        ptr_q          <= last ? '0 : ptr_q + PW'(1);
        if (last) begin
          spikes       <= acc_hit;
          spikes_valid <= 1'b1;
          acc_q        <= '0;
        end else begin
          acc_q <= acc_hit;
        end
      end
    end
  end

`ifdef ADAPTIVE_THRESH_EN
  localparam logic [WIDTH-1:0] OFF_STEP = WIDTH'(1) << (WIDTH - 4);

  logic [WIDTH-1:0] off_q [NUM_NEURONS];
  logic [WIDTH-1:0] nxt_off;
  logic [31:0]      off_inc;

  assign cur_off = off_q[ptr_q];
  assign off_inc = sat_add(32'(cur_off), 32'(OFF_STEP), WIDTH);

  always_comb begin
    nxt_off = cur_off;
    if (spike) nxt_off = off_inc[WIDTH-1:0];
    else if (ref_q[ptr_q] == '0 && cur_off != '0)
      nxt_off = cur_off - WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) off_q[i] <= '0;
    end else if (fsm_q == CLEAR) begin
      off_q[ptr_q] <= '0;
    end else if (beat) begin
      off_q[ptr_q] <= nxt_off;
    end
  end
`else
  assign cur_off = '0;
`endif

endmodule

// File: tb/tb_lif_array.sv
// Self-checking bench for lif_array: vector tables plus scoreboard queue.
// Build with ADAPTIVE_THRESH_EN defined to also exercise adaptive thresholds.
module tb_lif_array;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] threshold = '0;
  logic [7:0] current = '0;
  logic       in_ready;
  logic [7:0] state_out;
  logic [1:0] state_idx;
  logic       spike_out;
  logic [3:0] spikes;
  logic       spikes_valid;

  typedef struct {
    logic [7:0] st;
    logic       sp;
    logic       sv;
    logic [3:0] spikes;
  } exp_t;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] thr;
    logic [7:0] st;
    logic       sp;
  } vec_t;

  exp_t sbq[$];
  exp_t me;
  vec_t tbl[$];

  int n_cmp = 0;
  int n_bad = 0;
  int sv_count = 0;
  int exp_ptr = 0;
  logic [3:0] exp_acc = '0;
  logic hs_m;

  always #5 clk = ~clk;

  lif_array dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .threshold    (threshold),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .current      (current),
    .state_out    (state_out),
    .state_idx    (state_idx),
    .spike_out    (spike_out),
    .spikes       (spikes),
    .spikes_valid (spikes_valid)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t",
               name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    hs_m = in_valid && in_ready && reset_n;
    #1;
    if (hs_m) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got beat, required none");
      end else begin
        me = sbq.pop_front();
        check("state_out", 32'(state_out), 32'(me.st));
        check("spike_out", 32'(spike_out), 32'(me.sp));
        check("spikes_valid", 32'(spikes_valid), 32'(me.sv));
        if (me.sv) check("spikes", 32'(spikes), 32'(me.spikes));
      end
    end else if (reset_n) begin
      check("idle_spike", 32'(spike_out), 0);
      check("idle_sv", 32'(spikes_valid), 0);
    end
    if (spikes_valid) sv_count++;
  end

  task automatic drive(input logic [7:0] cur, input logic [7:0] thr,
                       input logic [7:0] st, input logic sp,
                       input bit rnd);
    bit hs;
    int tries;
    exp_t e;
    hs = 1'b0;
    tries = 0;
    while (!hs && tries < 64) begin
      @(negedge clk);
      check("state_idx", 32'(state_idx), 32'(exp_ptr));
      current = cur;
      threshold = thr;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hs = in_valid && in_ready;
      tries++;
    end
    if (!hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake: got none in %0d cycles", tries);
    end else begin
      e.st = st;
      e.sp = sp;
      e.sv = (exp_ptr == N - 1);
      e.spikes = exp_acc | (4'(sp) << exp_ptr);
      sbq.push_back(e);
      exp_acc = e.sv ? 4'b0 : e.spikes;
      exp_ptr = (exp_ptr + 1) % N;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_state_out", 32'(state_out), 0);
    check("rst_spike_out", 32'(spike_out), 0);
    check("rst_spikes", 32'(spikes), 0);
    check("rst_spikes_valid", 32'(spikes_valid), 0);
    check("rst_idx", 32'(state_idx), 0);
    check("rst_ready", 32'(in_ready), 1);
    exp_ptr = 0;
    exp_acc = '0;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i])
      drive(tbl[i].cur, tbl[i].thr, tbl[i].st, tbl[i].sp, 1'b0);
    tbl.delete();
  endtask

  task automatic add(input logic [7:0] cur, input logic [7:0] thr,
                     input logic [7:0] st, input logic sp);
    vec_t r;
    r.cur = cur;
    r.thr = thr;
    r.st = st;
    r.sp = sp;
    tbl.push_back(r);
  endtask

  logic [7:0] n0_st [6] = '{8'd100, 8'd175, 8'd232, 8'd0, 8'd0, 8'd100};
  logic [7:0] n1_cur [5] = '{8'd250, 8'd255, 8'd0, 8'd0, 8'd10};
  logic [7:0] n1_st [5] = '{8'd250, 8'd255, 8'd0, 8'd0, 8'd10};
  logic [7:0] a_cur [8] = '{255, 255, 255, 255, 255, 255, 231, 57};
  logic [7:0] a_st [8] = '{255, 0, 0, 255, 0, 0, 231, 231};
  logic       a_sp [8] = '{1, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int sv0;

    do_reset();

    // integrate, fire, refractory, re-integrate on neuron 0
    for (int s = 0; s < 6; s++)
      for (int n = 0; n < N; n++)
        if (n == 0) add(8'd100, 8'd200, n0_st[s], s == 2);
        else add(8'd0, 8'd200, 8'd0, 1'b0);
    run_tbl();
    idle(2);

    // saturation on neuron 1 at threshold 255
    do_reset();
    for (int s = 0; s < 5; s++)
      for (int n = 0; n < N; n++)
        if (n == 1) add(n1_cur[s], 8'd255, n1_st[s], s == 1);
        else add(8'd0, 8'd255, 8'd0, 1'b0);
    run_tbl();
    idle(2);

    // random in_valid gaps
    do_reset();
    sv0 = sv_count;
    for (int i = 0; i < 12; i++)
      drive(8'd0, 8'd255, 8'd0, 1'b0, 1'b1);
    idle(2);
    check("sv_pulses", 32'(sv_count - sv0), 3);

    // threshold 0 fires every neuron, then reset mid-sweep
    for (int n = 0; n < N; n++)
      add(8'(n + 5), 8'd0, 8'(n + 5), 1'b1);
    add(8'd40, 8'd200, 8'd0, 1'b0);
    add(8'd40, 8'd200, 8'd0, 1'b0);
    run_tbl();
    idle(1);
    do_reset();
    for (int n = 0; n < N; n++)
      add(8'(50 + 10 * n), 8'd200, 8'(50 + 10 * n), 1'b0);
    add(8'd0, 8'd200, 8'd38, 1'b0);
    add(8'd0, 8'd200, 8'd45, 1'b0);
    run_tbl();

    // clear with a competing beat at ptr 2
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    current = 8'd99;
    #1 check("clr_ready", 32'(in_ready), 0);
    check("clr_idx", 32'(state_idx), 2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear = (i == 1);
      #1 check("clr_busy", 32'(in_ready), 0);
    end
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    #1 check("clr_done_ready", 32'(in_ready), 1);
    check("clr_done_idx", 32'(state_idx), 0);
    exp_ptr = 0;
    exp_acc = '0;
    for (int n = 0; n < N; n++)
      add(8'(11 * (n + 1)), 8'd200, 8'(11 * (n + 1)), 1'b0);
    run_tbl();
    idle(2);

`ifdef ADAPTIVE_THRESH_EN
    do_reset();
    for (int s = 0; s < 8; s++)
      for (int n = 0; n < N; n++)
        if (n == 0) add(a_cur[s], 8'd200, a_st[s], a_sp[s]);
        else add(8'd0, 8'd200, 8'd0, 1'b0);
    run_tbl();
    idle(2);
`endif

    idle(3);
    check("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

endmodule
